// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, Rcon table, FSM state type, GF(2^8) helpers.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   // Round constants for rounds 1..10, round 1 in the most significant byte.
   localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } aes_state_e;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Round constant for a 1-based round number; zero outside 1..10.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [6:0] lsb;
      if (round == 4'd0 || int'(round) > NUM_ROUNDS) begin
         return 8'h00;
      end
      lsb = 7'(8 * (NUM_ROUNDS - int'(round)));
      return RCON_TABLE[lsb +: 8];
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] sbox_in,
   output logic [7:0] sbox_out
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   logic [7:0] p2, p4, p8, p16, p32, p64, p128, inv;

   // Inverse as x^254 = x^2 * x^4 * ... * x^128 (maps 0 to 0), then affine transform.
   always_comb begin
      // NOTE: blocking assignments here because each line consumes the value
      // produced by the line above within the same evaluation.
      p2   = gf_mul(sbox_in, sbox_in);
      p4   = gf_mul(p2, p2);
      p8   = gf_mul(p4, p4);
      p16  = gf_mul(p8, p8);
      p32  = gf_mul(p16, p16);
      p64  = gf_mul(p32, p32);
      p128 = gf_mul(p64, p64);
      inv  = gf_mul(p2, p4);
      inv  = gf_mul(inv, p8);
      inv  = gf_mul(inv, p16);
      inv  = gf_mul(inv, p32);
      inv  = gf_mul(inv, p64);
      inv  = gf_mul(inv, p128);
      sbox_out = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryptor: one round per clock, on-the-fly key expansion.
// Optional feature: define AES_DATA_OUT_COMP_EN to add complementary output ports.
module aes_top
   import aes_pkg::*;
(
   input  logic         AES_clk,
   input  logic         AES_rst_n,
   input  logic         AES_en,
   input  logic [127:0] AES_data_in,
   input  logic [127:0] AES_key_in,
   output logic [127:0] AES_data_out,
   output logic         AES_data_out_valid
`ifdef AES_DATA_OUT_COMP_EN
   ,
   output logic [127:0] AES_data_out_complementary,
   output logic         AES_data_out_complementary_valid
`endif
);

   aes_state_e   fsm_q, fsm_d;
   logic [3:0]   round_q, round_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [127:0] data_out_q, data_out_d;
   logic         valid_q, valid_d;

   logic [127:0] sub_bytes, shifted, mixed, next_key;
   logic [31:0]  ks_sub, ks_temp;
   logic [31:0]  nw0, nw1, nw2, nw3;
   logic [7:0]   a0, a1, a2, a3;

   // Byte i of a 128-bit word sits at bits [127-8i -: 8]; state byte index = row + 4*col.
   for (genvar i = 0; i < 16; i++) begin : g_state_sbox
      aes_sbox u_sbox (
         .sbox_in  (state_q[127-8*i -: 8]),
         .sbox_out (sub_bytes[127-8*i -: 8])
      );
   end

   for (genvar j = 0; j < 4; j++) begin : g_key_sbox
      aes_sbox u_sbox (
         .sbox_in  (rkey_q[31-8*j -: 8]),
         .sbox_out (ks_sub[31-8*j -: 8])
      );
   end

   // Round datapath: ShiftRows and MixColumns on the substituted state.
   always_comb begin
      shifted = '0;
      mixed   = '0;
      a0 = '0; a1 = '0; a2 = '0; a3 = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = shifted[127-8*(4*c)   -: 8];
         a1 = shifted[127-8*(4*c+1) -: 8];
         a2 = shifted[127-8*(4*c+2) -: 8];
         a3 = shifted[127-8*(4*c+3) -: 8];
         mixed[127-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mixed[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mixed[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mixed[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
   end

   // Next round key from the current one: SubWord(RotWord(w3)) ^ Rcon, then chained XORs.
   always_comb begin
      ks_temp  = {ks_sub[23:0], ks_sub[31:24]} ^ {rcon(round_q), 24'h000000};
      nw0      = rkey_q[127:96] ^ ks_temp;
      nw1      = rkey_q[95:64]  ^ nw0;
      nw2      = rkey_q[63:32]  ^ nw1;
      nw3      = rkey_q[31:0]   ^ nw2;
      next_key = {nw0, nw1, nw2, nw3};
   end

   // Next-state logic: capture in IDLE, one round per cycle in RUN, final round publishes.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      fsm_d      = fsm_q;
      round_d    = round_q;
      state_d    = state_q;
      rkey_d     = rkey_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      case (fsm_q)
         IDLE: begin
            if (AES_en) begin
               state_d = AES_data_in ^ AES_key_in;
               rkey_d  = AES_key_in;
               round_d = 4'd1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            rkey_d = next_key;
            if (round_q == 4'(NUM_ROUNDS)) begin
               state_d    = shifted ^ next_key;
               data_out_d = shifted ^ next_key;
               valid_d    = 1'b1;
               round_d    = 4'd0;
               fsm_d      = IDLE;
            end else begin
               state_d = mixed ^ next_key;
               round_d = round_q + 4'd1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State register with asynchronous active-high reset.
   always_ff @(posedge AES_clk or posedge AES_rst_n) begin
      if (AES_rst_n) begin
         // NOTE: the wide state/key registers are cleared as well so an abandoned
         // block leaves no key or intermediate state behind after reset.
         fsm_q      <= IDLE;
         round_q    <= 4'd0;
         state_q    <= '0;
         rkey_q     <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         round_q    <= round_d;
         state_q    <= state_d;
         rkey_q     <= rkey_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
      end
   end

   assign AES_data_out       = data_out_q;
   assign AES_data_out_valid = valid_q;

`ifdef AES_DATA_OUT_COMP_EN
   assign AES_data_out_complementary       = ~data_out_q;
   assign AES_data_out_complementary_valid = valid_q;
`endif

endmodule

// File: tb/tb_aes_top.sv
// Scoreboard bench for aes_top: stimulus pushes expected results, a monitor pops on valid.
module tb_aes_top;

   logic         clk;
   logic         rst;
   logic         en;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic [127:0] data_out;
   logic         data_out_valid;
`ifdef AES_DATA_OUT_COMP_EN
   logic [127:0] comp_out;
   logic         comp_valid;
`endif

   typedef struct {
      logic [127:0] data;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_top dut (
      .AES_clk            (clk),
      .AES_rst_n          (rst),
      .AES_en             (en),
      .AES_data_in        (data_in),
      .AES_key_in         (key_in),
      .AES_data_out       (data_out),
      .AES_data_out_valid (data_out_valid)
`ifdef AES_DATA_OUT_COMP_EN
      ,
      .AES_data_out_complementary       (comp_out),
      .AES_data_out_complementary_valid (comp_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (data_out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 128'd1, 128'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ciphertext", data_out, e.data);
            check("latency_cycle", 128'(cyc), 128'(e.cyc));
`ifdef AES_DATA_OUT_COMP_EN
            check("comp_out", comp_out, ~e.data);
            check("comp_valid", 128'(comp_valid), 128'd1);
`endif
         end
      end
   end

   // One-cycle start pulse; expectation is valid at the negedge 10 edges after capture.
   task automatic start_block(input logic [127:0] key, input logic [127:0] pt,
                              input logic [127:0] exp, input bit track);
      @(negedge clk);
      key_in  = key;
      data_in = pt;
      en      = 1'b1;
      @(negedge clk);
      en = 1'b0;
      if (track) sb.push_back('{data: exp, cyc: cyc + 10});
   endtask

   task automatic wait_drain(input int max_cycles);
      for (int i = 0; i < max_cycles && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", 128'(sb.size()), 128'd0);
         sb.delete();
      end
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b0;
      data_in = '0;
      key_in  = '0;
      repeat (2) @(negedge clk);
      check("reset_data_out", data_out, 128'd0);
      check("reset_valid", 128'(data_out_valid), 128'd0);
`ifdef AES_DATA_OUT_COMP_EN
      check("reset_comp_out", comp_out, {128{1'b1}});
      check("reset_comp_valid", 128'(comp_valid), 128'd0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_no_start", data_out, 128'd0);

      // Known-answer vectors.
      start_block(KEY_A, PT_A, CT_A, 1'b1);
      wait_drain(30);
      start_block(KEY_B, PT_B, CT_B, 1'b1);
      wait_drain(30);

      // All-zero vector with inputs disturbed during RUN.
      start_block('0, '0, CT_Z, 1'b1);
      @(negedge clk);
      data_in = PT_A;
      key_in  = KEY_A;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en      = 1'b0;
      data_in = PT_B;
      key_in  = KEY_B;
      wait_drain(30);
      repeat (5) @(negedge clk);
      check("hold_after_zero", data_out, CT_Z);
      check("valid_low_hold", 128'(data_out_valid), 128'd0);

      // Enable held for 51 edges: five back-to-back blocks spaced 11 cycles.
      @(negedge clk);
      key_in  = KEY_B;
      data_in = PT_B;
      en      = 1'b1;
      for (int k = 0; k < 5; k++) sb.push_back('{data: CT_B, cyc: cyc + 11 + 11 * k});
      repeat (51) @(posedge clk);
      @(negedge clk);
      en = 1'b0;
      wait_drain(40);
      repeat (15) @(negedge clk);
      check("hold_after_stream", data_out, CT_B);

      // Reset at round 5 abandons the block; the next start is clean.
      start_block(KEY_A, PT_A, CT_A, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrun_reset_out", data_out, 128'd0);
      check("midrun_reset_valid", 128'(data_out_valid), 128'd0);
`ifdef AES_DATA_OUT_COMP_EN
      check("midrun_reset_comp", comp_out, {128{1'b1}});
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check("no_pulse_after_reset", data_out, 128'd0);
      start_block(KEY_A, PT_A, CT_A, 1'b1);
      wait_drain(30);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 128'(sb.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
